// File: rtl/mu0_pkg.sv
// mu0_pkg: shared definitions for the MU0 control unit.
//   - opcode constants (LDA..STP; 8-F are illegal)
//   - ALU function codes driven on M
//   - FSM state encoding (2-bit)
//   - select-value constants for X, Y and address multiplexers
//   - ctrl_t: the raw select/enable/request vector produced by the decoder
package mu0_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JGE = 4'h5;
  localparam logic [3:0] OP_JNE = 4'h6;
  localparam logic [3:0] OP_STP = 4'h7;

  localparam logic [1:0] M_Y   = 2'b00;
  localparam logic [1:0] M_ADD = 2'b01;
  localparam logic [1:0] M_INC = 2'b10;
  localparam logic [1:0] M_SUB = 2'b11;

  localparam logic SEL_ACC     = 1'b0;  // X mux
  localparam logic SEL_PC      = 1'b1;
  localparam logic SEL_DIN     = 1'b0;  // Y mux
  localparam logic SEL_IR      = 1'b1;
  localparam logic SEL_ADDR_PC = 1'b0;  // address mux
  localparam logic SEL_ADDR_IR = 1'b1;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_HALT    = 2'b10
  } state_t;

  // Bit order matches the 10-bit vector passed between decoder and top.
  typedef struct packed {
    logic       x_sel;
    logic       y_sel;
    logic       addr_sel;
    logic       pc_en;
    logic       ir_en;
    logic       acc_en;
    logic [1:0] m;
    logic       rd;
    logic       wr;
  } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// mu0_decode: purely combinational decoder.
//   state  in  2   current FSM state (state_t encoding)
//   f      in  4   opcode
//   n, z   in  1   Acc negative / zero flags
//   ctrl   out 10  raw ctrl_t vector, enables assume the access completes
//   stop   out 1   execute of STP or an illegal opcode
//   bad_op out 1   execute of an illegal opcode (8-F)
module mu0_decode
  import mu0_pkg::*;
(
  input  logic [1:0] state,
  input  logic [3:0] f,
  input  logic       n,
  input  logic       z,
  output logic [9:0] ctrl,
  output logic       stop,
  output logic       bad_op
);

  ctrl_t c;

  always_comb begin
    c      = '0;
    stop   = 1'b0;
    bad_op = 1'b0;
    case (state)
      ST_FETCH: begin
        c.addr_sel = SEL_ADDR_PC;
        c.rd       = 1'b1;
        c.x_sel    = SEL_PC;
        c.m        = M_INC;
        c.ir_en    = 1'b1;
        c.pc_en    = 1'b1;
      end
      ST_EXECUTE: begin
        case (f)
          OP_LDA: begin
            c.addr_sel = SEL_ADDR_IR;
            c.rd       = 1'b1;
            c.y_sel    = SEL_DIN;
            c.m        = M_Y;
            c.acc_en   = 1'b1;
          end
          OP_STA: begin
            c.addr_sel = SEL_ADDR_IR;
            c.x_sel    = SEL_ACC;
            c.wr       = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            c.addr_sel = SEL_ADDR_IR;
            c.rd       = 1'b1;
            c.x_sel    = SEL_ACC;
            c.y_sel    = SEL_DIN;
            c.m        = (f == OP_ADD) ? M_ADD : M_SUB;
            c.acc_en   = 1'b1;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            // Branch selects are driven regardless; only the PC load is conditional.
            c.y_sel = SEL_IR;
            c.m     = M_Y;
            c.pc_en = (f == OP_JMP) ? 1'b1 :
                      (f == OP_JGE) ? ~n : ~z;
          end
          OP_STP: stop = 1'b1;
          default: begin
            stop   = 1'b1;
            bad_op = 1'b1;
          end
        endcase
      end
      default: ;  // HALT: everything inactive
    endcase
  end

  assign ctrl = c;

endmodule

// File: rtl/mu0_control.sv
// mu0_control: MU0 control unit with a request/acknowledge memory handshake.
//   CNT_W        param  width of the retired-instruction counter
//   Clk          in     clock, rising edge
//   Reset        in     synchronous, active-low reset
//   F, N, Z      in     opcode and Acc flags from the datapath
//   Mem_Ack      in     memory completes the current Rd/Wr this cycle
//   X_sel, Y_sel, Addr_sel, M            out  datapath selects / ALU function
//   PC_En, IR_En, Acc_En                 out  register load enables
//   Rd, Wr                               out  memory requests
//   Halted, Illegal, Instr_Count         out  status (registered)
module mu0_control
  import mu0_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [3:0]       F,
  input  logic             N,
  input  logic             Z,
  input  logic             Mem_Ack,
  output logic             X_sel,
  output logic             Y_sel,
  output logic             Addr_sel,
  output logic             PC_En,
  output logic             IR_En,
  output logic             Acc_En,
  output logic [1:0]       M,
  output logic             Rd,
  output logic             Wr,
  output logic             Halted,
  output logic             Illegal,
  output logic [CNT_W-1:0] Instr_Count
);

  state_t           state_reg, state_next;
  logic             halted_reg, illegal_reg;
  logic [CNT_W-1:0] count_reg;
  logic [9:0]       raw_vec;
  ctrl_t            raw;
  logic             stop, bad_op;
  logic             mem_req, go, retire;

  mu0_decode u_decode (
    .state  (state_reg),
    .f      (F),
    .n      (N),
    .z      (Z),
    .ctrl   (raw_vec),
    .stop   (stop),
    .bad_op (bad_op)
  );

  assign raw     = ctrl_t'(raw_vec);
  assign mem_req = raw.rd | raw.wr;
  // Enables of a memory step wait for the acknowledge; reset kills everything.
  assign go      = Reset & (mem_req ? Mem_Ack : 1'b1);

  assign X_sel    = raw.x_sel;
  assign Y_sel    = raw.y_sel;
  assign Addr_sel = raw.addr_sel;
  assign M        = raw.m;
  assign PC_En    = raw.pc_en  & go;
  assign IR_En    = raw.ir_en  & go;
  assign Acc_En   = raw.acc_en & go;
  assign Rd       = raw.rd & Reset;
  assign Wr       = raw.wr & Reset;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:   if (Mem_Ack) state_next = ST_EXECUTE;
      ST_EXECUTE: begin
        if (stop)                     state_next = ST_HALT;
        else if (!mem_req || Mem_Ack) state_next = ST_FETCH;
      end
      ST_HALT:    state_next = ST_HALT;
      default:    state_next = ST_FETCH;
    endcase
  end

  assign retire = (state_reg == ST_EXECUTE) && (state_next != ST_EXECUTE);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_reg   <= ST_FETCH;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == ST_HALT) halted_reg  <= 1'b1;
      if (retire && bad_op)      illegal_reg <= 1'b1;
      if (retire)                count_reg   <= count_reg + CNT_W'(1);
    end
  end

  assign Halted      = halted_reg;
  assign Illegal     = illegal_reg;
  assign Instr_Count = count_reg;

endmodule
